// File: rtl/osc_spi_pkg.sv
// Shared constants, state encoding and helpers for the SPI command sequencer.
package osc_spi_pkg;

    // Width of one SPI frame word.
    localparam int SPI_W = 16;

    // Fixed state codes, so other tools can decode the state register as plain bits.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_BUSY  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        BUSY  = ST_BUSY,
        RESP  = ST_RESP,
        GAP   = ST_GAP
    } seq_state_t;

    // Larger of two integers; used to size the shared gap/timeout counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_cmd_seq_if.sv
// Bundle of the sequencer's host-side request/response ports and its SPI-master handshake.
interface spi_cmd_seq_if;
    import osc_spi_pkg::*;

    // Command request from the host side.
    logic             req_vld;
    logic             req_rdy;
    logic [SPI_W-1:0] req_cmd;
    logic             req_rd;

    // Read-data response back to the host side.
    logic             rsp_vld;
    logic             rsp_rdy;
    logic [SPI_W-1:0] rsp_data;

    // Status and error handling.
    logic             busy;
    logic             err_timeout;
    logic             clr_err;

    // Handshake with the SPI master.
    logic             wrt;
    logic [SPI_W-1:0] cmd;
    logic             done;
    logic [SPI_W-1:0] data;

    // The sequencer itself.
    modport slave (
        input  req_vld, req_cmd, req_rd,
        output req_rdy,
        output rsp_vld, rsp_data,
        input  rsp_rdy,
        output busy, err_timeout,
        input  clr_err,
        output wrt, cmd,
        input  done, data
    );

    // Whatever drives the sequencer: host plus SPI master.
    modport master (
        output req_vld, req_cmd, req_rd,
        input  req_rdy,
        input  rsp_vld, rsp_data,
        output rsp_rdy,
        input  busy, err_timeout,
        output clr_err,
        input  wrt, cmd,
        output done, data
    );

endinterface

// File: rtl/cmd_fifo.sv
// Small register-array FIFO; the head entry is visible on dout_o without a read register.
module cmd_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells full (same index, different lap) from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO refuses a push even when the head leaves on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset flushes the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/spi_cmd_seq.sv
// Command sequencer in front of the SPI master: queues commands, issues one frame at a time,
// returns read words, enforces an inter-frame gap and flags frames whose done never arrives.
module spi_cmd_seq
    import osc_spi_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_cmd_seq_if.slave bus
);

    // One counter serves both the gap wait and the BUSY timeout; they never overlap.
    localparam int CNT_W = $clog2(max_int(GAP_CYC, TIMEOUT_CYC) + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    // With no gap configured a finished frame returns straight to IDLE.
    localparam seq_state_t POST_FRAME = (GAP_CYC > 0) ? GAP : IDLE;

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SPI_W-1:0] cmd_q;
    logic [SPI_W-1:0] cmd_d;
    logic             rd_q;
    logic             rd_d;
    logic             wrt_q;
    logic             wrt_d;
    logic             rsp_vld_q;
    logic             rsp_vld_d;
    logic [SPI_W-1:0] rsp_data_q;
    logic [SPI_W-1:0] rsp_data_d;
    logic             err_q;
    logic             err_d;
    logic             err_set;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [SPI_W:0]   fifo_dout;

    // Each entry is {read-back flag, command word}.
    cmd_fifo #(
        .WIDTH (SPI_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.req_vld),
        .pop_i   (fifo_pop),
        .din_i   ({bus.req_rd, bus.req_cmd}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Frame sequencing: pop, start pulse, wait for done or timeout, optional response, gap.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        rd_d       = rd_q;
        wrt_d      = 1'b0;
        rsp_vld_d  = rsp_vld_q;
        rsp_data_d = rsp_data_q;
        err_set    = 1'b0;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_dout[SPI_W-1:0];
                    rd_d     = fifo_dout[SPI_W];
                    wrt_d    = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (bus.done) begin
                    cnt_d = '0;
                    if (rd_q) begin
                        rsp_data_d = bus.data;
                        rsp_vld_d  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        state_d = POST_FRAME;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_set = 1'b1;
                    cnt_d   = '0;
                    state_d = POST_FRAME;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = POST_FRAME;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.clr_err) begin
            err_d = 1'b0;
        end
    end

    // Sequencer state and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            rd_q       <= 1'b0;
            wrt_q      <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            rd_q       <= rd_d;
            wrt_q      <= wrt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_rdy     = !fifo_full;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.busy        = (state_q != IDLE) || !fifo_empty;
    assign bus.err_timeout = err_q;
    assign bus.wrt         = wrt_q;
    assign bus.cmd         = cmd_q;

endmodule
